router_nch: RTL and testbench

- Parametrised successor of the 3-port byte router: one input packet stream routed to NUM_CH output channels.
- Each channel has its own FIFO.
- Header carries destination and payload length. The trailing byte is an XOR parity check.
- Adds, over the previous generation: configurable width, depth and channel count; explicit length-based framing; bad-address drop; per-channel read timeout flush.

---
 rtl/router_nch.sv | 240 ++++++++++++++++++++++++
 tb/tb_router_nch.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_nch.sv
// -----------------------------------------------------------------------------
// router_nch
//   Routes one byte-wide packet stream to NUM_CH output channels, each backed
//   by its own FIFO.
//
//   Packet layout:
//     header : [ADDR_W-1:0] = dest, [DATA_W-1:ADDR_W] = len
//     payload: len bytes
//     parity : XOR of the header and all payload bytes
//   Headers that address a channel >= NUM_CH are discarded together with the
//   rest of their packet, and err pulses once.
//
//   Optional feature macro: ROUTER_SOFT_RESET_EN
//     Defined   - each channel flushes itself after TIMEOUT consecutive cycles
//                 of holding data without being read.
//     Undefined - channels hold their data until it is read.
//
// Ports
//   clock     : rising-edge clock
//   reset     : asynchronous active-high reset
//   pkt_valid : data_in carries a byte this cycle
//   data_in   : packet byte
//   busy      : byte on data_in not accepted this cycle (combinational)
//   err       : one-cycle pulse for a bad address or a parity mismatch
//   read_enb  : per-channel pop request
//   vld_out   : per-channel FIFO non-empty
//   data_out  : per-channel read data, lane i at [i*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module router_nch #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pkt_valid,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     busy,
  output logic                     err,
  input  logic [NUM_CH-1:0]        read_enb,
  output logic [NUM_CH-1:0]        vld_out,
  output logic [NUM_CH*DATA_W-1:0] data_out
);

  localparam int              PW      = $clog2(FIFO_DEPTH);
  localparam int              LEN_W   = DATA_W - ADDR_W;
  localparam int              CW      = LEN_W + 1;
  localparam int              NA      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] NCH     = (ADDR_W+1)'(NUM_CH);
  localparam logic [PW:0]     PTR_ONE = (PW+1)'(1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, DROP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] dest_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] par_q;

  logic [PW:0]       wr_ptr [NUM_CH];
  logic [PW:0]       rd_ptr [NUM_CH];
  logic [DATA_W-1:0] mem    [NUM_CH][FIFO_DEPTH];
  logic [DATA_W-1:0] dout_q [NUM_CH];

  logic [NUM_CH-1:0] full, empty, wr_en, rd_en, flush;
  logic [NA-1:0]     full_ext, flush_ext;
  logic [ADDR_W-1:0] hdr_dest;
  logic [LEN_W-1:0]  hdr_len;
  logic              hdr_ok, accept, flush_dest;

  // Bytes still owed by the source when a flush turns a live packet into a
  // drop: remaining payload plus parity, minus the byte taken this cycle.
  function automatic logic [CW-1:0] drop_rem(input state_t st, input logic [CW-1:0] cnt,
                                             input logic acc);
    logic [CW-1:0] left;
    left = (st == PAYLOAD) ? cnt + CW'(1) : CW'(1);
    return left - CW'(acc);
  endfunction

  assign hdr_dest = data_in[ADDR_W-1:0];
  assign hdr_len  = data_in[DATA_W-1:ADDR_W];
  assign hdr_ok   = ({1'b0, hdr_dest} < NCH);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      full[i]  = (wr_ptr[i][PW] != rd_ptr[i][PW]) &&
                 (wr_ptr[i][PW-1:0] == rd_ptr[i][PW-1:0]);
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
    end
  end

  // Channel-indexed views padded to the full address range so that an
  // out-of-range dest never indexes past the vector.
  always_comb begin
    full_ext  = '0;
    flush_ext = '0;
    full_ext[NUM_CH-1:0]  = full;
    flush_ext[NUM_CH-1:0] = flush;
  end

  assign flush_dest = flush_ext[dest_q];
  assign vld_out    = ~empty;

  always_comb begin
    busy = 1'b0;
    case (state)
      IDLE:            busy = pkt_valid & hdr_ok & full_ext[hdr_dest];
      PAYLOAD, PARITY: busy = pkt_valid & full_ext[dest_q];
      default:         busy = 1'b0;
    endcase
  end

  assign accept = pkt_valid & ~busy;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_en[i] = accept & ~flush[i] &
                 (((state == IDLE) & hdr_ok & (hdr_dest == ADDR_W'(i))) |
                  (((state == PAYLOAD) | (state == PARITY)) & (dest_q == ADDR_W'(i))));
      rd_en[i] = read_enb[i] & ~empty[i];
    end
  end

  // ---- packet framing FSM ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      dest_q <= '0;
      cnt_q  <= '0;
      par_q  <= '0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (hdr_ok) begin
              dest_q <= hdr_dest;
              cnt_q  <= {1'b0, hdr_len};
              par_q  <= data_in;
              state  <= (hdr_len != '0) ? PAYLOAD : PARITY;
            end else begin
              err   <= 1'b1;
              cnt_q <= {1'b0, hdr_len} + CW'(1);
              state <= DROP;
            end
          end
        end
        PAYLOAD: begin
          if (flush_dest) begin
            cnt_q <= drop_rem(state, cnt_q, accept);
            state <= DROP;
          end else if (accept) begin
            par_q <= par_q ^ data_in;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state <= PARITY;
          end
        end
        PARITY: begin
          if (flush_dest) begin
            cnt_q <= drop_rem(state, cnt_q, accept);
            state <= accept ? IDLE : DROP;
          end else if (accept) begin
            err   <= (data_in != par_q);
            state <= IDLE;
          end
        end
        default: begin
          if (accept) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state <= IDLE;
          end
        end
      endcase
    end
  end

  // ---- channel FIFO pointers and read registers ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (flush[i]) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
        end else begin
          if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
          if (rd_en[i]) begin
            rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
            dout_q[i] <= mem[i][rd_ptr[i][PW-1:0]];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en[i]) mem[i][wr_ptr[i][PW-1:0]] <= data_in;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign data_out[g*DATA_W +: DATA_W] = dout_q[g];
  end

`ifdef ROUTER_SOFT_RESET_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_cnt [NUM_CH];

  // Flush fires on the edge where the idle count would reach TIMEOUT, so a
  // channel stays visible for exactly TIMEOUT cycles without a read.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      flush[i] = ~empty[i] & ~read_enb[i] & (idle_cnt[i] == TW'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) idle_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (empty[i] | read_enb[i] | flush[i]) idle_cnt[i] <= '0;
        else                                    idle_cnt[i] <= idle_cnt[i] + TW'(1);
      end
    end
  end
`else
  assign flush = '0;
`endif

endmodule

// File: tb/tb_router_nch.sv
module tb_router_nch;

`ifdef ROUTER_SOFT_RESET_EN
  localparam bit SR = 1'b1;
`else
  localparam bit SR = 1'b0;
`endif
  localparam int TIMEOUT = 30;
  localparam int DEPTH   = 16;
  localparam int TO_HI   = SR ? TIMEOUT : 60;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pkt_valid = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        busy, err;
  logic [2:0]  read_enb = 3'b000;
  logic [2:0]  vld_out;
  logic [23:0] data_out;

  int n_vec = 0;
  int n_err = 0;

  router_nch dut (
    .clock    (clock),
    .reset    (reset),
    .pkt_valid(pkt_valid),
    .data_in  (data_in),
    .busy     (busy),
    .err      (err),
    .read_enb (read_enb),
    .vld_out  (vld_out),
    .data_out (data_out)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       pv;
    logic [7:0] din;
    logic [2:0] rd;
    logic       ebusy;
    logic [2:0] evld;
    logic       eerr;
    int         lane;
    logic [7:0] edout;
  } vec_t;

  vec_t tq[$];

  task automatic add(input logic pv, input logic [7:0] din, input logic [2:0] rd,
                     input logic ebusy, input logic [2:0] evld, input logic eerr,
                     input int lane, input logic [7:0] edout);
    vec_t v;
    v.pv = pv; v.din = din; v.rd = rd; v.ebusy = ebusy;
    v.evld = evld; v.eerr = eerr; v.lane = lane; v.edout = edout;
    tq.push_back(v);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] mq[3][$];
  logic [7:0] mdout[3];
  logic       merr;
  bit         in_pkt, mbad;
  int         mleft, mdst;
  logic [7:0] mxr;
  int         midle[3];
  logic [7:0] sq[$];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mdout[i] = 8'h00;
      midle[i] = 0;
    end
    merr = 1'b0; in_pkt = 0; mbad = 0; mleft = 0; mdst = 0; mxr = 8'h00;
    sq.delete();
  endtask

  function automatic logic model_busy(input logic pv, input logic [7:0] din);
    int d;
    if (!pv) return 1'b0;
    if (!in_pkt) begin
      d = int'(din[1:0]);
      if (d >= 3) return 1'b0;
      return mq[d].size() == DEPTH;
    end
    if (mbad) return 1'b0;
    return mq[mdst].size() == DEPTH;
  endfunction

  task automatic model_step(input logic pv, input logic [7:0] din, input logic [2:0] rd,
                            input logic bsy, output logic acc);
    logic [2:0] fl;
    logic       was_rt, err_n;
    int         d;
    acc = pv & ~bsy;
    fl = 3'b000;
    err_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (mq[i].size() != 0 && !rd[i]) begin
        if (SR && midle[i] == TIMEOUT - 1) begin
          fl[i] = 1'b1;
          midle[i] = 0;
        end else midle[i]++;
      end else midle[i] = 0;
    end
    for (int i = 0; i < 3; i++)
      if (rd[i] && mq[i].size() != 0) mdout[i] = mq[i].pop_front();
    for (int i = 0; i < 3; i++)
      if (fl[i]) mq[i].delete();
    was_rt = in_pkt && !mbad && fl[mdst];
    if (acc) begin
      if (!in_pkt) begin
        d = int'(din[1:0]);
        in_pkt = 1;
        mleft = int'(din[7:2]) + 1;
        if (d < 3) begin
          mbad = 0; mdst = d; mxr = din;
          if (!fl[d]) mq[d].push_back(din);
        end else begin
          mbad = 1; err_n = 1'b1;
        end
      end else begin
        mleft--;
        if (!mbad && !fl[mdst]) begin
          mq[mdst].push_back(din);
          if (mleft == 0) err_n = (din != mxr);
          else mxr = mxr ^ din;
        end
        if (mleft == 0) in_pkt = 0;
      end
    end
    if (was_rt && in_pkt) mbad = 1;
    merr = err_n;
  endtask

  task automatic gen_pkt();
    logic [7:0] hdr, x, b;
    int len;
    len = $urandom_range(0, 9);
    hdr = {6'(len), 2'($urandom_range(0, 3))};
    x = hdr;
    sq.push_back(hdr);
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      x = x ^ b;
      sq.push_back(b);
    end
    sq.push_back(($urandom_range(0, 4) == 0) ? (x ^ 8'h5A) : x);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; pkt_valid = 1'b0; read_enb = 3'b000; data_in = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] bp[$];
    logic [7:0] x;
    int idx, nr, hi, cyc;
    bit stopped, done, will_acc, will_rd;
    logic mb, acc;

    // ---- reset state ----
    pkt_valid = 1'b1; data_in = 8'h01;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_vld", 0, 32'(vld_out), 0);
    chk("rst_dout", 0, 32'(data_out), 0);
    chk("rst_err", 0, 32'(err), 0);
    chk("rst_busy", 0, 32'(busy), 0);
    pkt_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // ---- table: normal packet, parity error, bad address ----
    add(1, 8'h0D, 3'b000, 0, 3'b010, 0, -1, 8'h00);
    add(1, 8'h11, 3'b000, 0, 3'b010, 0, -1, 8'h00);
    add(1, 8'h22, 3'b000, 0, 3'b010, 0, -1, 8'h00);
    add(1, 8'h33, 3'b000, 0, 3'b010, 0, -1, 8'h00);
    add(1, 8'h0D, 3'b000, 0, 3'b010, 0, -1, 8'h00);
    add(0, 8'h00, 3'b010, 0, 3'b010, 0, 1, 8'h0D);
    add(0, 8'h00, 3'b010, 0, 3'b010, 0, 1, 8'h11);
    add(0, 8'h00, 3'b010, 0, 3'b010, 0, 1, 8'h22);
    add(0, 8'h00, 3'b010, 0, 3'b010, 0, 1, 8'h33);
    add(0, 8'h00, 3'b010, 0, 3'b000, 0, 1, 8'h0D);
    add(1, 8'h0D, 3'b000, 0, 3'b010, 0, -1, 8'h00);
    add(1, 8'h11, 3'b000, 0, 3'b010, 0, -1, 8'h00);
    add(1, 8'h22, 3'b000, 0, 3'b010, 0, -1, 8'h00);
    add(1, 8'h33, 3'b000, 0, 3'b010, 0, -1, 8'h00);
    add(1, 8'h00, 3'b000, 0, 3'b010, 1, -1, 8'h00);
    add(0, 8'h00, 3'b010, 0, 3'b010, 0, 1, 8'h0D);
    add(0, 8'h00, 3'b010, 0, 3'b010, 0, 1, 8'h11);
    add(0, 8'h00, 3'b010, 0, 3'b010, 0, 1, 8'h22);
    add(0, 8'h00, 3'b010, 0, 3'b010, 0, 1, 8'h33);
    add(0, 8'h00, 3'b010, 0, 3'b000, 0, 1, 8'h00);
    add(1, 8'h07, 3'b000, 0, 3'b000, 1, -1, 8'h00);
    add(1, 8'hAA, 3'b000, 0, 3'b000, 0, -1, 8'h00);
    add(1, 8'hBB, 3'b000, 0, 3'b000, 0, -1, 8'h00);
    add(1, 8'h00, 3'b000, 0, 3'b001, 0, -1, 8'h00);
    add(1, 8'h00, 3'b000, 0, 3'b001, 0, -1, 8'h00);
    add(0, 8'h00, 3'b001, 0, 3'b001, 0, 0, 8'h00);
    add(0, 8'h00, 3'b001, 0, 3'b000, 0, 0, 8'h00);

    for (int k = 0; k < tq.size(); k++) begin
      @(negedge clock);
      pkt_valid = tq[k].pv; data_in = tq[k].din; read_enb = tq[k].rd;
      #1;
      chk("tbl_busy", k, 32'(busy), 32'(tq[k].ebusy));
      @(posedge clock);
      #1;
      chk("tbl_vld", k, 32'(vld_out), 32'(tq[k].evld));
      chk("tbl_err", k, 32'(err), 32'(tq[k].eerr));
      if (tq[k].lane >= 0)
        chk("tbl_dout", k, 32'(data_out[tq[k].lane*8 +: 8]), 32'(tq[k].edout));
    end

    // ---- backpressure: len 20 to ch0 ----
    x = 8'h50;
    bp.push_back(x);
    for (int k = 0; k < 20; k++) begin
      bp.push_back(8'(8'hA0 + k));
      x = x ^ 8'(8'hA0 + k);
    end
    bp.push_back(x);
    idx = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      pkt_valid = 1'b1; data_in = bp[idx]; read_enb = 3'b000;
      #1;
      chk("bp_fill_busy", k, 32'(busy), 0);
      @(posedge clock);
      idx++;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      data_in = bp[idx];
      #1;
      chk("bp_full_busy", k, 32'(busy), 1);
    end
    @(negedge clock);
    read_enb = 3'b001;
    #1;
    chk("bp_rd_busy", 0, 32'(busy), 1);
    @(posedge clock);
    #1;
    chk("bp_first_read", 0, 32'(data_out[7:0]), 32'(bp[0]));
    nr = 1;
    @(negedge clock);
    read_enb = 3'b000;
    #1;
    chk("bp_one_more", 0, 32'(busy), 0);
    @(posedge clock);
    idx++;
    @(negedge clock);
    data_in = bp[idx];
    #1;
    chk("bp_full_again", 0, 32'(busy), 1);
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      read_enb = 3'b001;
      if (idx < bp.size()) begin pkt_valid = 1'b1; data_in = bp[idx]; end
      else pkt_valid = 1'b0;
      #1;
      will_acc = pkt_valid & ~busy;
      will_rd  = vld_out[0];
      @(posedge clock);
      #1;
      if (will_acc) idx++;
      if (will_rd) begin
        chk("bp_drain_data", nr, 32'(data_out[7:0]), (nr < bp.size()) ? 32'(bp[nr]) : 32'hFFFF);
        nr++;
      end
      if (idx == bp.size() && vld_out[0] == 1'b0) done = 1;
    end
    chk("bp_drain_done", 0, 32'(done), 1);
    chk("bp_bytes_out", 0, 32'(nr), 32'(bp.size()));

    // ---- timeout: 0-length packet to ch2, never read ----
    @(negedge clock);
    pkt_valid = 1'b1; data_in = 8'h02; read_enb = 3'b000;
    @(posedge clock);
    #1;
    hi = vld_out[2] ? 1 : 0;
    stopped = !vld_out[2];
    for (int c = 1; c < 60; c++) begin
      @(negedge clock);
      pkt_valid = (c == 1); data_in = 8'h02;
      @(posedge clock);
      #1;
      if (!vld_out[2]) stopped = 1;
      else if (!stopped) hi++;
    end
    chk("timeout_hi_cycles", 0, 32'(hi), 32'(TO_HI));
    @(negedge clock);
    read_enb = 3'b100;
    repeat (3) @(negedge clock);
    read_enb = 3'b000;
    #1;
    chk("timeout_drained", 0, 32'(vld_out), 0);

    // ---- reset in the middle of a len-5 packet to ch0 ----
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      pkt_valid = 1'b1; data_in = (k == 0) ? 8'h14 : 8'(8'h40 + k);
    end
    @(negedge clock);
    chk("mid_pre_vld", 0, 32'(vld_out), 32'b001);
    data_in = 8'h99; reset = 1'b1;
    #1;
    chk("mid_rst_vld", 0, 32'(vld_out), 0);
    chk("mid_rst_dout", 0, 32'(data_out), 0);
    chk("mid_rst_err", 0, 32'(err), 0);
    chk("mid_rst_busy", 0, 32'(busy), 0);
    pkt_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    bp.delete();
    bp.push_back(8'h05); bp.push_back(8'h77); bp.push_back(8'h72);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      pkt_valid = 1'b1; data_in = bp[k];
      #1;
      chk("post_busy", k, 32'(busy), 0);
      @(posedge clock);
      #1;
      chk("post_vld", k, 32'(vld_out), 32'b010);
      chk("post_err", k, 32'(err), 0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      pkt_valid = 1'b0; read_enb = 3'b010;
      @(posedge clock);
      #1;
      chk("post_read", k, 32'(data_out[15:8]), 32'(bp[k]));
    end
    chk("post_empty", 0, 32'(vld_out), 0);

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int rp;
      rp = (c < 1500) ? 60 : 12;
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        chk("rnd_vld", c, 32'(vld_out[i]), 32'(mq[i].size() != 0));
        chk("rnd_dout", c, 32'(data_out[i*8 +: 8]), 32'(mdout[i]));
      end
      chk("rnd_err", c, 32'(err), 32'(merr));
      if (sq.size() == 0) gen_pkt();
      pkt_valid = ($urandom_range(0, 3) != 0);
      data_in = sq[0];
      for (int i = 0; i < 3; i++) read_enb[i] = ($urandom_range(0, 99) < rp);
      #1;
      mb = model_busy(pkt_valid, data_in);
      chk("rnd_busy", c, 32'(busy), 32'(mb));
      model_step(pkt_valid, data_in, read_enb, mb, acc);
      if (acc) void'(sq.pop_front());
    end
    cyc = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
